// File: rtl/exec_decode_mem_unit_if.sv
// Execute-stage bus: instruction/operands in, decoded controls, ALU, memory
// and next-PC information out.
interface exec_decode_mem_unit_if;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  dest_idx;
  logic        reg_wr;
  logic [31:0] wb_data;
  logic [31:0] alu_result;
  logic        zero;
  logic        carryout;
  logic        overflow;
  logic [31:0] mem_rdata;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        illegal;

  modport master (
    output instr, pc_in, rs_data, rt_data,
    input  rs_idx, rt_idx, dest_idx, reg_wr, wb_data, alu_result, zero,
           carryout, overflow, mem_rdata, pc_sel, branch_target,
           jump_target, illegal
  );

  modport slave (
    input  instr, pc_in, rs_data, rt_data,
    output rs_idx, rt_idx, dest_idx, reg_wr, wb_data, alu_result, zero,
           carryout, overflow, mem_rdata, pc_sel, branch_target,
           jump_target, illegal
  );
endinterface

// File: rtl/exec_decode_mem_unit.sv
// Execute slice of the single-cycle MIPS-subset CPU: decoder, 32-bit ALU with
// flags, and word-addressed data memory with async-clear reset.
module exec_decode_mem_unit #(
  parameter int unsigned DM_ADDR_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  exec_decode_mem_unit_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** DM_ADDR_W;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_XORI  = 6'b001110,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR  = 6'b001000,
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_SLT = 6'b101010
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_SLT  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_OR   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } dest_sel_e;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] imm_ext;

  alu_op_e     alu_op;
  dest_sel_e   dest_sel;
  logic        use_imm;
  logic        zext;
  logic        is_lw;
  logic        is_sw;
  logic        is_jal;
  logic        is_bne;
  logic        is_jump;
  logic        is_jr;
  logic        reg_wr_d;
  logic        illegal_d;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_b_eff;
  logic [32:0] sum33;
  logic [31:0] alu_res;
  logic        alu_cout;
  logic        alu_ovf;
  logic        add_ovf;

  logic [31:0]          mem [DEPTH];
  logic [DM_ADDR_W-1:0] mem_addr;
  logic [31:0]          pc_plus4;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];
  assign imm16  = bus.instr[15:0];

  // Decoder
  always_comb begin
    alu_op    = ALU_ADD;
    dest_sel  = DST_RT;
    use_imm   = 1'b0;
    zext      = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_jal    = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    reg_wr_d  = 1'b0;
    illegal_d = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_sel = DST_RD;
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; reg_wr_d = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; reg_wr_d = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; reg_wr_d = 1'b1; end
          FN_JR:  is_jr = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      OP_ADDI: begin use_imm = 1'b1; reg_wr_d = 1'b1; end
      OP_XORI: begin
        alu_op   = ALU_XOR;
        use_imm  = 1'b1;
        zext     = 1'b1;
        reg_wr_d = 1'b1;
      end
      OP_LW:   begin use_imm = 1'b1; is_lw = 1'b1; reg_wr_d = 1'b1; end
      OP_SW:   begin use_imm = 1'b1; is_sw = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; is_bne = 1'b1; end
      OP_J:    is_jump = 1'b1;
      OP_JAL: begin
        is_jump  = 1'b1;
        is_jal   = 1'b1;
        dest_sel = DST_RA;
        reg_wr_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  assign imm_ext = zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

  // ALU
  assign op_a     = bus.rs_data;
  assign op_b     = use_imm ? imm_ext : bus.rt_data;
  // SLT shares the subtractor path so its sign/overflow come from A-B
  assign op_b_eff = (alu_op == ALU_ADD) ? op_b : ~op_b;
  assign sum33    = {1'b0, op_a} + {1'b0, op_b_eff} + {32'd0, (alu_op != ALU_ADD)};
  assign add_ovf  = (op_a[31] == op_b_eff[31]) && (sum33[31] != op_a[31]);

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_op)
      ALU_ADD, ALU_SUB: begin
        alu_res  = sum33[31:0];
        alu_cout = sum33[32];
        alu_ovf  = add_ovf;
      end
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = {31'd0, sum33[31] ^ add_ovf};
      ALU_AND:  alu_res = op_a & op_b;
      ALU_NAND: alu_res = ~(op_a & op_b);
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_OR:   alu_res = op_a | op_b;
      default:  alu_res = '0;
    endcase
  end

  // Data memory: async read, sync write, async clear on reset
  assign mem_addr = alu_res[DM_ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (is_sw) begin
      mem[mem_addr] <= bus.rt_data;
    end
  end

  assign pc_plus4 = bus.pc_in + 32'd4;

  assign bus.rs_idx        = bus.instr[25:21];
  assign bus.rt_idx        = bus.instr[20:16];
  assign bus.dest_idx      = (dest_sel == DST_RD) ? bus.instr[15:11] :
                             (dest_sel == DST_RA) ? 5'd31 : bus.instr[20:16];
  assign bus.reg_wr        = reg_wr_d;
  assign bus.alu_result    = alu_res;
  assign bus.zero          = (alu_res == '0);
  assign bus.carryout      = alu_cout;
  assign bus.overflow      = alu_ovf;
  assign bus.mem_rdata     = mem[mem_addr];
  assign bus.wb_data       = is_jal ? pc_plus4 : (is_lw ? mem[mem_addr] : alu_res);
  assign bus.pc_sel        = is_jump ? 2'b10 :
                             is_jr   ? 2'b11 :
                             (is_bne && (alu_res != '0)) ? 2'b01 : 2'b00;
  assign bus.branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign bus.jump_target   = {bus.pc_in[31:28], bus.instr[25:0], 2'b00};
  assign bus.illegal       = illegal_d;

endmodule

// File: tb/tb_exec_decode_mem_unit.sv
// Directed self-checking bench for exec_decode_mem_unit.
module tb_exec_decode_mem_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  exec_decode_mem_unit_if bus ();

  exec_decode_mem_unit #(.DM_ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.instr   = i;
    bus.pc_in   = pc;
    bus.rs_data = rs;
    bus.rt_data = rt;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(32'h8C0A_0014, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", bus.mem_rdata, 32'h0); end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_addi;
    drive(32'h2011_0005, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if ({bus.reg_wr, bus.dest_idx, bus.pc_sel, bus.illegal} !== {1'b1, 5'd17, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL addi_ctrl: got wr=%b dst=%0d sel=%b ill=%b want 1/17/00/0", bus.reg_wr, bus.dest_idx, bus.pc_sel, bus.illegal);
    end
    n_checks++;
    if ({bus.alu_result, bus.wb_data} !== {32'd5, 32'd5}) begin
      n_fail++; $display("FAIL addi_result: got alu=%h wb=%h want 5/5", bus.alu_result, bus.wb_data);
    end
  endtask

  task automatic test_add;
    drive(32'h0232_8020, 32'h0, 32'd5, 32'd19);
    n_checks++;
    if ({bus.dest_idx, bus.alu_result, bus.zero, bus.rs_idx, bus.rt_idx} !== {5'd16, 32'd24, 1'b0, 5'd17, 5'd18}) begin
      n_fail++; $display("FAIL add_basic: got dst=%0d alu=%h z=%b rs=%0d rt=%0d want 16/18/0/17/18", bus.dest_idx, bus.alu_result, bus.zero, bus.rs_idx, bus.rt_idx);
    end
    drive(32'h0232_8020, 32'h0, 32'h7FFF_FFFF, 32'd1);
    n_checks++;
    if ({bus.alu_result, bus.overflow, bus.carryout} !== {32'h8000_0000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_ovf: got alu=%h ov=%b c=%b want 80000000/1/0", bus.alu_result, bus.overflow, bus.carryout);
    end
    drive(32'h0232_8020, 32'h0, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if ({bus.alu_result, bus.zero, bus.carryout, bus.overflow} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_carry: got alu=%h z=%b c=%b ov=%b want 0/1/1/0", bus.alu_result, bus.zero, bus.carryout, bus.overflow);
    end
    drive(32'h0232_8022, 32'h0, 32'h8000_0000, 32'd1);
    n_checks++;
    if ({bus.alu_result, bus.overflow, bus.reg_wr} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sub_ovf: got alu=%h ov=%b wr=%b want 7fffffff/1/1", bus.alu_result, bus.overflow, bus.reg_wr);
    end
  endtask

  task automatic test_mem;
    @(negedge clk);
    drive(32'hAC09_0004, 32'h0, 32'h10, 32'hDEAD_BEEF);
    n_checks++;
    if ({bus.reg_wr, bus.alu_result, bus.mem_rdata} !== {1'b0, 32'h14, 32'h0}) begin
      n_fail++; $display("FAIL sw_pre: got wr=%b alu=%h rd=%h want 0/14/0", bus.reg_wr, bus.alu_result, bus.mem_rdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_post: got %h want deadbeef", bus.mem_rdata); end
    @(negedge clk);
    drive(32'h8C0A_0014, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if ({bus.mem_rdata, bus.wb_data, bus.dest_idx, bus.reg_wr} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd10, 1'b1}) begin
      n_fail++; $display("FAIL lw: got rd=%h wb=%h dst=%0d wr=%b want deadbeef/deadbeef/10/1", bus.mem_rdata, bus.wb_data, bus.dest_idx, bus.reg_wr);
    end
    drive(32'h8C0A_0014, 32'h0, 32'h400, 32'h0);
    n_checks++;
    if (bus.wb_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_wrap: got %h want deadbeef", bus.wb_data); end
    drive(32'h8C0A_0014, 32'h0, 32'h4, 32'h0);
    n_checks++;
    if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL lw_other: got %h want 0", bus.mem_rdata); end
  endtask

  task automatic test_branch;
    drive(32'h1509_FFFE, 32'h100, 32'd3, 32'd3);
    n_checks++;
    if ({bus.zero, bus.pc_sel, bus.reg_wr, bus.carryout} !== {1'b1, 2'b00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL bne_eq: got z=%b sel=%b wr=%b c=%b want 1/00/0/1", bus.zero, bus.pc_sel, bus.reg_wr, bus.carryout);
    end
    drive(32'h1509_FFFE, 32'h100, 32'd3, 32'd4);
    n_checks++;
    if ({bus.pc_sel, bus.branch_target} !== {2'b01, 32'h0FC}) begin
      n_fail++; $display("FAIL bne_ne: got sel=%b tgt=%h want 01/000000fc", bus.pc_sel, bus.branch_target);
    end
  endtask

  task automatic test_jump;
    drive(32'h0C00_0040, 32'h20, 32'h0, 32'h0);
    n_checks++;
    if ({bus.dest_idx, bus.wb_data, bus.pc_sel, bus.jump_target, bus.reg_wr} !== {5'd31, 32'h24, 2'b10, 32'h100, 1'b1}) begin
      n_fail++; $display("FAIL jal: got dst=%0d wb=%h sel=%b tgt=%h wr=%b want 31/24/10/100/1", bus.dest_idx, bus.wb_data, bus.pc_sel, bus.jump_target, bus.reg_wr);
    end
    drive(32'h0800_0040, 32'hA000_0000, 32'h0, 32'h0);
    n_checks++;
    if ({bus.pc_sel, bus.jump_target, bus.reg_wr} !== {2'b10, 32'hA000_0100, 1'b0}) begin
      n_fail++; $display("FAIL j: got sel=%b tgt=%h wr=%b want 10/a0000100/0", bus.pc_sel, bus.jump_target, bus.reg_wr);
    end
    drive(32'h03E0_0008, 32'h20, 32'h44, 32'h0);
    n_checks++;
    if ({bus.pc_sel, bus.reg_wr, bus.illegal} !== {2'b11, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL jr: got sel=%b wr=%b ill=%b want 11/0/0", bus.pc_sel, bus.reg_wr, bus.illegal);
    end
  endtask

  task automatic test_misc;
    drive(32'h0232_802A, 32'h0, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if ({bus.alu_result, bus.carryout, bus.overflow} !== {32'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL slt_neg: got alu=%h c=%b ov=%b want 1/0/0", bus.alu_result, bus.carryout, bus.overflow);
    end
    drive(32'h0232_802A, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000);
    n_checks++;
    if (bus.alu_result !== 32'd0) begin n_fail++; $display("FAIL slt_ovf: got %h want 0", bus.alu_result); end
    drive(32'h3800_FFFF, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if ({bus.alu_result, bus.dest_idx} !== {32'h0000_FFFF, 5'd0}) begin
      n_fail++; $display("FAIL xori: got alu=%h dst=%0d want 0000ffff/0", bus.alu_result, bus.dest_idx);
    end
    drive(32'hFC00_0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if ({bus.illegal, bus.reg_wr, bus.pc_sel} !== {1'b1, 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL illegal_op: got ill=%b wr=%b sel=%b want 1/0/00", bus.illegal, bus.reg_wr, bus.pc_sel);
    end
    drive(32'h0232_803F, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if ({bus.illegal, bus.reg_wr} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL illegal_funct: got ill=%b wr=%b want 1/0", bus.illegal, bus.reg_wr);
    end
  endtask

  task automatic test_reset_mem;
    // word 5 holds DEADBEEF from the earlier store
    @(negedge clk);
    drive(32'h8C0A_0014, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_pre: got %h want deadbeef", bus.mem_rdata); end
    rst_n = 1'b0; #1;
    n_checks++;
    if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_clear: got %h want 0", bus.mem_rdata); end
    drive(32'hAC09_0004, 32'h0, 32'h10, 32'h1234_5678);
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_sw_blocked: got %h want 0", bus.mem_rdata); end
    @(negedge clk);
    drive(32'h8C0A_0014, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1; #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_after: got %h want 0", bus.mem_rdata); end
    @(negedge clk);
    drive(32'hAC09_0004, 32'h0, 32'h10, 32'h0BAD_F00D);
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_first_write: got %h want 0badf00d", bus.mem_rdata); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_addi();
    test_add();
    test_mem();
    test_branch();
    test_jump();
    test_misc();
    test_reset_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
